id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the register file in the 5-stage MIPS core.
- Captures both register read operands, the sign-extended immediate, register specifiers and decoded control for the EX stage.
- Detects load-use hazards and forwards same-cycle WB writes that the register file cannot yet return.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_W, 32, operand/PC width
- ALUOP_W, 4, ALU operation code width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold all stage contents
- flush  input  1  replace stage contents with bubble
- id_valid  input  1  ID holds a real instruction
- id_pc_plus4  input  DATA_W  PC+4 of ID instruction
- id_read_data_1  input  DATA_W  register file port 1 data (rs)
- id_read_data_2  input  DATA_W  register file port 2 data (rt)
- id_rs, id_rt, id_rd  input  5 each  register specifiers
- id_imm  input  16  raw immediate field
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decoded control
- id_alu_op  input  ALUOP_W  ALU operation
- wb_reg_write  input  1  WB stage writes register file this cycle
- wb_write_reg  input  5  WB destination
- wb_write_data  input  DATA_W  WB data
- ex_valid  output  1  EX holds a real instruction
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  output  DATA_W each  registered operands
- ex_rs, ex_rt, ex_dest  output  5 each  registered specifiers; ex_dest is the resolved destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  output  1 each  registered control
- ex_alu_op  output  ALUOP_W  registered ALU operation
- load_use_hazard  output  1  combinational; upstream IF/ID must hold

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0; ex_valid=0. load_use_hazard therefore reads 0.
- Per-edge priority: flush > stall > load_use_hazard bubble > capture.
  - flush: bubble, i.e. ex_valid=0, all control 0, all data/specifiers 0.
  - stall: every register holds its value.
  - load_use_hazard=1 without stall/flush: bubble as for flush; the instruction stays in ID and is captured on the next non-hazard edge.
  - capture: all ex_* take the id_* values; ex_valid=id_valid. When id_valid=0, control is forced to 0.
- Immediate: ex_imm = sign-extend(id_imm) to DATA_W.
- Destination: ex_dest = id_reg_dst ? id_rd : id_rt, resolved at capture.
- Register $0: ex_rs_data=0 when id_rs=0 and ex_rt_data=0 when id_rt=0, regardless of port data or bypass.
- load_use_hazard = ex_valid & ex_mem_read & ex_rt!=0 & id_valid & (ex_rt==id_rs | ex_rt==id_rt).
  - Uses registered EX state only; no combinational path from the WB inputs.
- Latency: 1 cycle ID to EX. No internal multi-cycle state beyond the valid bit.
- Simultaneous stall and flush: flush wins.
- Reset deasserted mid-stall: first post-reset edge obeys the normal priority with zeroed state.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: at capture, when wb_reg_write=1, wb_write_reg!=0 and wb_write_reg==id_rs, ex_rs_data takes wb_write_data instead of id_read_data_1. The same rule applies to id_rt and ex_rt_data. The $0 rule still has precedence.
- Undefined: operands come only from the register file ports; the WB inputs are unused. Software or scheduling must separate a WB write and a dependent ID read by one cycle.

Test Plan:
- Reset: assert rst_n=0 mid-capture with ex_reg_write=1 -> all outputs 0 immediately, before the next clk edge.
- Capture: id_imm=16'h8004, id_reg_dst=1, id_rd=7, id_rt=3, id_valid=1 -> next cycle ex_imm=32'hFFFF8004, ex_dest=7, ex_valid=1.
- Load-use: EX holds lw (mem_read=1, rt=5); ID holds add with rs=5 -> load_use_hazard=1. Next edge inserts a bubble (ex_valid=0, ex_reg_write=0); the following edge captures the add.
- Stall/flush: stall=1 for 3 cycles -> outputs unchanged. stall=1 and flush=1 together -> bubble.
- Zero register: id_rs=0, id_read_data_1=32'hDEADBEEF -> ex_rs_data=0. With WB_BYPASS_EN and wb_write_reg=0 -> ex_rs_data still 0.
- Bypass: with WB_BYPASS_EN, wb_reg_write=1, wb_write_reg=9, wb_write_data=32'h12345678, id_rt=9, id_read_data_2=32'h0 -> ex_rt_data=32'h12345678. Without the macro -> ex_rt_data=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection; optional WB bypass when WB_BYPASS_EN is defined.
// Latency: 1 cycle ID to EX; load_use_hazard is combinational from registered EX state only.
// Backpressure: stall holds every register, flush or a load-use hazard loads a bubble, flush has top priority.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc_plus4,
    input  logic [DATA_W-1:0]  id_read_data_1,
    input  logic [DATA_W-1:0]  id_read_data_2,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic [15:0]        id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               wb_reg_write,
    input  logic [4:0]         wb_write_reg,
    input  logic [DATA_W-1:0]  wb_write_data,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc_plus4,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_dest,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               load_use_hazard
);

    logic [DATA_W-1:0] rs_dat;
    logic [DATA_W-1:0] rt_dat;
    logic [DATA_W-1:0] imm_ext;
    logic              bubble;

`ifndef WB_BYPASS_EN
    logic wb_unused;
    assign wb_unused = ^{wb_reg_write, wb_write_reg, wb_write_data};
`endif

    // $0 override comes last so it beats both the port data and the bypass
    always_comb begin
        rs_dat = id_read_data_1;
        rt_dat = id_read_data_2;
`ifdef WB_BYPASS_EN
        if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rs))
            rs_dat = wb_write_data;
        if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rt))
            rt_dat = wb_write_data;
`endif
        if (id_rs == 5'd0)
            rs_dat = '0;
        if (id_rt == 5'd0)
            rt_dat = '0;
    end

    assign imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};

    assign load_use_hazard = ex_valid && ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                             ((ex_rt == id_rs) || (ex_rt == id_rt));

    assign bubble = flush || (!stall && load_use_hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            ex_valid      <= 1'b0;
            ex_pc_plus4   <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_pc_plus4   <= id_pc_plus4;
            ex_rs_data    <= rs_dat;
            ex_rt_data    <= rt_dat;
            ex_imm        <= imm_ext;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_dest       <= id_reg_dst ? id_rd : id_rt;
            ex_reg_write  <= id_valid && id_reg_write;
            ex_mem_read   <= id_valid && id_mem_read;
            ex_mem_write  <= id_valid && id_mem_write;
            ex_mem_to_reg <= id_valid && id_mem_to_reg;
            ex_alu_src    <= id_valid && id_alu_src;
            ex_alu_op     <= id_valid ? id_alu_op : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use bubble, stall/flush, $0 and WB bypass.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_pc_plus4, id_read_data_1, id_read_data_2;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_op;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_valid;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic        load_use_hazard;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.DATA_W(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_pc_plus4 = 0; id_read_data_1 = 0; id_read_data_2 = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_alu_src = 0; id_reg_dst = 0; id_alu_op = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_ctl"}, {24'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                            ex_alu_src, 3'd0}, 32'd0);
        chk({tag, "_pc"}, ex_pc_plus4, 32'd0);
        chk({tag, "_dat"}, ex_rs_data | ex_rt_data | ex_imm, 32'd0);
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        id_clear();
        #12;
        chk_bubble("rst");
        chk("rst_hz", {31'd0, load_use_hazard}, 32'd0);
        @(negedge clk) rst_n = 1;

        // asynchronous reset asserted mid-cycle
        id_valid = 1; id_reg_write = 1; id_pc_plus4 = 32'h44; id_rs = 1; id_read_data_1 = 32'h11;
        step();
        chk("pre_rst_rw", {31'd0, ex_reg_write}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk_bubble("async_rst");
        @(negedge clk) rst_n = 1;

        // capture with sign extension and rd destination
        id_clear();
        id_valid = 1; id_pc_plus4 = 32'h100; id_rs = 2; id_rt = 3; id_rd = 7; id_imm = 16'h8004;
        id_read_data_1 = 32'hAAAA_0001; id_read_data_2 = 32'hBBBB_0002;
        id_reg_dst = 1; id_reg_write = 1; id_alu_src = 1; id_alu_op = 4'h6;
        step();
        chk("cap_imm", ex_imm, 32'hFFFF_8004);
        chk("cap_dest", {27'd0, ex_dest}, 32'd7);
        chk("cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap_rs", ex_rs_data, 32'hAAAA_0001);
        chk("cap_rt", ex_rt_data, 32'hBBBB_0002);
        chk("cap_pc", ex_pc_plus4, 32'h100);
        chk("cap_aluop", {28'd0, ex_alu_op}, 32'h6);
        chk("cap_ctl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src},
            32'b10001);

        // positive immediate, rt destination
        id_imm = 16'h7FFF; id_reg_dst = 0;
        step();
        chk("pos_imm", ex_imm, 32'h0000_7FFF);
        chk("rt_dest", {27'd0, ex_dest}, 32'd3);

        // invalid instruction: control forced low
        id_valid = 0; id_mem_write = 1;
        step();
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_ctl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src},
            32'd0);

        // load-use on rs
        id_clear();
        id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_src = 1;
        id_rs = 1; id_rt = 5; id_imm = 16'h0010;
        step();
        id_clear();
        id_valid = 1; id_rs = 5; id_rt = 6; id_rd = 8; id_reg_dst = 1; id_reg_write = 1;
        id_pc_plus4 = 32'h208; id_read_data_2 = 32'h66;
        #1;
        chk("lu_hz", {31'd0, load_use_hazard}, 32'd1);
        step();
        chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bub_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("lu_hz_clr", {31'd0, load_use_hazard}, 32'd0);
        step();
        chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_cap_rs", {27'd0, ex_rs}, 32'd5);
        chk("lu_cap_dest", {27'd0, ex_dest}, 32'd8);
        chk("lu_cap_pc", ex_pc_plus4, 32'h208);

        // load-use on rt; also no hazard for $0 target or invalid ID
        id_clear();
        id_valid = 1; id_mem_read = 1; id_rt = 4;
        step();
        id_clear();
        id_valid = 1; id_rs = 1; id_rt = 4;
        #1;
        chk("lu_rt_hz", {31'd0, load_use_hazard}, 32'd1);
        id_valid = 0;
        #1;
        chk("lu_inv_hz", {31'd0, load_use_hazard}, 32'd0);
        id_clear();
        id_valid = 1; id_mem_read = 1; id_rt = 0;
        step();
        id_clear();
        id_valid = 1; id_rs = 0; id_rt = 0;
        #1;
        chk("lu_r0_hz", {31'd0, load_use_hazard}, 32'd0);

        // stall holds for 3 cycles, even with hazard-causing ID
        id_clear();
        id_valid = 1; id_mem_read = 1; id_rt = 9; id_pc_plus4 = 32'h300; id_reg_write = 1;
        step();
        id_clear();
        stall = 1; id_valid = 1; id_rs = 9; id_pc_plus4 = 32'h304;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", ex_pc_plus4, 32'h300);
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        end
        flush = 1;
        step();
        chk_bubble("stall_flush");
        stall = 0; flush = 0;

        // $0 forcing, with WB targeting $0
        id_clear();
        id_valid = 1; id_rs = 0; id_rt = 2; id_read_data_1 = 32'hDEAD_BEEF; id_read_data_2 = 32'h22;
        wb_reg_write = 1; wb_write_reg = 0; wb_write_data = 32'hCAFE_F00D;
        step();
        chk("r0_rs", ex_rs_data, 32'd0);
        chk("r0_rt", ex_rt_data, 32'h22);

        // WB bypass on rt
        id_clear();
        id_valid = 1; id_rs = 1; id_rt = 9; id_read_data_1 = 32'h11; id_read_data_2 = 32'h0;
        wb_reg_write = 1; wb_write_reg = 9; wb_write_data = 32'h1234_5678;
        step();
`ifdef WB_BYPASS_EN
        chk("byp_rt", ex_rt_data, 32'h1234_5678);
`else
        chk("byp_rt", ex_rt_data, 32'h0);
`endif
        chk("byp_rs", ex_rs_data, 32'h11);

        // reset released while stall is high: first edge holds the zeroed state
        stall = 1;
        #2 rst_n = 0;
        #1;
        chk_bubble("rst_stall");
        @(negedge clk) rst_n = 1;
        id_clear();
        id_valid = 1; id_pc_plus4 = 32'h400;
        step();
        chk("rst_stall_hold", {31'd0, ex_valid}, 32'd0);
        stall = 0;
        step();
        chk("rst_stall_cap", ex_pc_plus4, 32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
